// File: rtl/spc7110_bank_mapper.sv
// spc7110_bank_mapper
//   Address mapper for an SPC7110-style cartridge. Holds the save-RAM
//   enable and up to three data-ROM window bank registers in the
//   $00-3F/$80-BF register space. Translates a sampled SNES address into
//   a cartridge ROM/save-RAM address one clock after MAP_REQ.
//
// Ports
//   CLK           system clock, rising edge
//   RST_N         asynchronous active-low reset
//   SNES_ADDR     requested SNES address (24 bit)
//   SNES_DATA_IN  register write data
//   REG_WR_STB    one-cycle register write pulse
//   MAP_REQ       one-cycle translation request
//   ROM_MASK      ROM size mask
//   SAVERAM_MASK  save-RAM size mask (bit 0 also gates save-RAM decode)
//   REG_HIT       combinational: SNES_ADDR selects a mapper register
//   REG_RD_DATA   combinational register readback (0 when no hit)
//   ROM_ADDR      registered translated address
//   ROM_HIT       registered, IS_ROM | IS_SAVERAM
//   IS_ROM        registered, result lies in program or data ROM
//   IS_SAVERAM    registered, result lies in save RAM
//   MAP_VALID     registered one-cycle result strobe
module spc7110_bank_mapper #(
    parameter int          NUM_WIN   = 3,
    parameter int          BANK_W    = 3,
    parameter logic [23:0] DROM_BASE = 24'h100000,
    parameter logic [15:0] REG_BASE  = 16'h4830
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        REG_WR_STB,
    input  logic        MAP_REQ,
    input  logic [23:0] ROM_MASK,
    input  logic [23:0] SAVERAM_MASK,
    output logic        REG_HIT,
    output logic [7:0]  REG_RD_DATA,
    output logic [23:0] ROM_ADDR,
    output logic        ROM_HIT,
    output logic        IS_ROM,
    output logic        IS_SAVERAM,
    output logic        MAP_VALID
);

    // Save-RAM address: bank bits 20:16 above the 8 KB page offset.
    function automatic logic [23:0] saveram_addr(input logic [23:0] a,
                                                 input logic [23:0] mask);
        return 24'hE00000 + (24'({a[20:16], a[12:0]}) & mask);
    endfunction

    // Data-ROM window: 24-bit add, carry out of bit 23 is dropped before masking.
    function automatic logic [23:0] window_addr(input logic [BANK_W-1:0] bank,
                                                input logic [23:0]       a,
                                                input logic [23:0]       mask);
        logic [23:0] sum;
        sum = DROM_BASE + 24'({bank, a[19:0]});
        return sum & mask;
    endfunction

    function automatic logic [23:0] prog_addr(input logic [23:0] a,
                                              input logic [23:0] mask);
        return {4'h0, a[19:0]} & mask;
    endfunction

    logic [BANK_W-1:0] bank_q [NUM_WIN];
    logic [BANK_W-1:0] bank_d [NUM_WIN];
    logic              sram_en_q, sram_en_d;

    logic [23:0] addr_q, addr_d;
    logic        is_rom_q, is_rom_d;
    logic        is_sram_q, is_sram_d;
    logic        hit_q;
    logic        valid_q;

    logic        bank_lo;
    logic [15:0] reg_off;
    logic        reg_hit;

    logic        sram_sel;
    logic        win_sel;
    logic        prog_sel;
    logic [BANK_W-1:0] win_bank;

    // Only bits 7 and BANK_W-1:0 of the write data carry state.
    logic unused_data;
    assign unused_data = ^SNES_DATA_IN;

    // Banks $00-3F and $80-BF are exactly those with address bit 22 clear.
    assign bank_lo = ~SNES_ADDR[22];
    assign reg_off = SNES_ADDR[15:0] - REG_BASE;
    assign reg_hit = bank_lo && (SNES_ADDR[15:0] >= REG_BASE)
                     && (reg_off <= 16'(NUM_WIN));

    assign REG_HIT = reg_hit;

    // Register write next-state
    always_comb begin
        bank_d    = bank_q;
        sram_en_d = sram_en_q;
        if (REG_WR_STB && reg_hit) begin
            if (reg_off == 16'd0) begin
                sram_en_d = SNES_DATA_IN[7];
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                if (reg_off == 16'(i + 1)) begin
                    bank_d[i] = SNES_DATA_IN[BANK_W-1:0];
                end
            end
        end
    end

    // Register readback
    always_comb begin
        REG_RD_DATA = 8'h00;
        if (reg_hit) begin
            if (reg_off == 16'd0) begin
                REG_RD_DATA = {sram_en_q, 7'b0};
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                if (reg_off == 16'(i + 1)) begin
                    REG_RD_DATA = 8'(bank_q[i]);
                end
            end
        end
    end

    // Translation decode; uses the current (pre-write) register contents.
    always_comb begin
        win_sel  = 1'b0;
        win_bank = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (SNES_ADDR[23:20] == 4'(13 + i)) begin
                win_sel  = 1'b1;
                win_bank = bank_q[i];
            end
        end
    end

    assign sram_sel = bank_lo && (SNES_ADDR[15:13] == 3'b011)
                      && sram_en_q && SAVERAM_MASK[0];
    assign prog_sel = (SNES_ADDR[23:20] == 4'hC) || (bank_lo && SNES_ADDR[15]);

    always_comb begin
        addr_d    = 24'h0;
        is_rom_d  = 1'b0;
        is_sram_d = 1'b0;
        if (sram_sel) begin
            addr_d    = saveram_addr(SNES_ADDR, SAVERAM_MASK);
            is_sram_d = 1'b1;
        end else if (win_sel) begin
            addr_d   = window_addr(win_bank, SNES_ADDR, ROM_MASK);
            is_rom_d = 1'b1;
        end else if (prog_sel) begin
            addr_d   = prog_addr(SNES_ADDR, ROM_MASK);
            is_rom_d = 1'b1;
        end
    end

    // Request -> result stage boundary
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                bank_q[i] <= BANK_W'(i);
            end
            sram_en_q <= 1'b0;
            addr_q    <= 24'h0;
            is_rom_q  <= 1'b0;
            is_sram_q <= 1'b0;
            hit_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            sram_en_q <= sram_en_d;
            valid_q   <= MAP_REQ;
            if (MAP_REQ) begin
                addr_q    <= addr_d;
                is_rom_q  <= is_rom_d;
                is_sram_q <= is_sram_d;
                hit_q     <= is_rom_d | is_sram_d;
            end
        end
    end

    assign ROM_ADDR   = addr_q;
    assign IS_ROM     = is_rom_q;
    assign IS_SAVERAM = is_sram_q;
    assign ROM_HIT    = hit_q;
    assign MAP_VALID  = valid_q;

endmodule
